// File: rtl/shared_memory_arbiter.sv
// shared_memory_arbiter: shares one block-wide data memory between the icache and dcache, one transaction at a time
// Ports:
//   clock, reset                 posedge clock, asynchronous active-high reset
//   i_read/i_address             icache block read request (held until i_busywait low)
//   i_readdata/i_busywait        icache returned block and handshake
//   d_read/d_write/d_address     dcache block request (write wins when both high)
//   d_writedata                  dcache block to write back
//   d_readdata/d_busywait        dcache returned block and handshake
//   mem_read/mem_write           command to data memory, driven from latched request only
//   mem_address/mem_writedata    latched address/data of the granted request
//   mem_readdata/mem_busywait    data memory response
module shared_memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_read,
  input  logic [5:0]  i_address,
  output logic [31:0] i_readdata,
  output logic        i_busywait,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [5:0]  d_address,
  input  logic [31:0] d_writedata,
  output logic [31:0] d_readdata,
  output logic        d_busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I, RELEASE} state_t;
  state_t     state, next_state;
  logic       served_d, op_write, started;
  logic [3:0] starve_cnt;
  logic       d_req, pick_d, in_grant, done;
  assign d_req    = d_read | d_write;
  // data side wins unless the instruction side has waited through LIMIT data grants
  assign pick_d   = d_req && (!i_read || starve_cnt < LIMIT);
  assign in_grant = state == GRANT_D || state == GRANT_I;
  // completion needs the memory to have gone busy first, so a late busywait is not mistaken for done
  assign done     = in_grant && started && !mem_busywait;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:             next_state = pick_d ? GRANT_D : i_read ? GRANT_I : IDLE;
      GRANT_D, GRANT_I: next_state = done ? RELEASE : state;
      default:          next_state = IDLE;
    endcase
  end
  always_comb begin
    mem_read   = in_grant && !op_write;
    mem_write  = in_grant && op_write;
    i_busywait = i_read && !(state == RELEASE && !served_d);
    d_busywait = d_req && !(state == RELEASE && served_d);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      served_d      <= 1'b0;
      op_write      <= 1'b0;
      started       <= 1'b0;
      starve_cnt    <= 4'd0;
      mem_address   <= 6'd0;
      mem_writedata <= 32'd0;
      i_readdata    <= 32'd0;
      d_readdata    <= 32'd0;
    end else begin
      started <= in_grant && (started || mem_busywait);
      if (state == IDLE && next_state != IDLE) begin
        served_d    <= pick_d;
        op_write    <= pick_d && d_write;
        mem_address <= pick_d ? d_address : i_address;
        if (pick_d) mem_writedata <= d_writedata;
      end
      if (state == IDLE)
        starve_cnt <= !i_read || next_state == GRANT_I ? 4'd0 :
                      next_state == GRANT_D && starve_cnt < LIMIT ? starve_cnt + 4'd1 : starve_cnt;
      if (done && !op_write && served_d)  d_readdata <= mem_readdata;
      if (done && !op_write && !served_d) i_readdata <= mem_readdata;
    end
  end
endmodule

// File: tb/tb_shared_memory_arbiter.sv
// tb_shared_memory_arbiter: directed checks of the arbiter against a small busywait memory model
module tb_shared_memory_arbiter;
  logic        clock, reset;
  logic        i_read, d_read, d_write;
  logic [5:0]  i_address, d_address;
  logic [31:0] d_writedata, i_readdata, d_readdata;
  logic        i_busywait, d_busywait;
  logic        mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  int          vectors = 0, miscompares = 0;
  int          mem_b = 5, cnt, log_n, k, n0;
  logic [31:0] wmem [64];
  logic        written [64];
  logic        log_w [64];
  logic [5:0]  log_a [64];
  shared_memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [31:0] init_word(input logic [5:0] a);
    case (a)
      6'h15:   return 32'hDEADBEEF;
      6'h16:   return 32'h0BADF00D;
      6'h2A:   return 32'hCAFEF00D;
      6'h3F:   return 32'hFFFF0000;
      6'h03:   return 32'h33333333;
      default: return {26'd0, a};
    endcase
  endfunction
  function automatic logic [31:0] rd(input logic [5:0] a);
    return written[a] ? wmem[a] : init_word(a);
  endfunction
  // memory stays busy for mem_b cycles of an asserted command, then completes on the next edge
  assign mem_busywait = (mem_read || mem_write) && cnt < mem_b;
  assign mem_readdata = rd(mem_address);
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 0;
      for (int j = 0; j < 64; j++) written[j] <= 1'b0;
    end else if (mem_read || mem_write) begin
      if (cnt < mem_b) cnt <= cnt + 1;
      else begin
        if (mem_write) begin
          wmem[mem_address]    <= mem_writedata;
          written[mem_address] <= 1'b1;
        end
        log_w[log_n] <= mem_write;
        log_a[log_n] <= mem_address;
        log_n        <= log_n + 1;
        cnt          <= 0;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_low(input bit d, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((d ? d_busywait : i_busywait) && n < 100);
    if (n >= 100) chk("busywait_timeout", 32'(d ? d_busywait : i_busywait), 32'd0);
  endtask
  initial begin
    log_n = 0;
    reset = 1'b1;
    {i_read, d_read, d_write} = 3'b000;
    i_address = 6'd0; d_address = 6'd0; d_writedata = 32'd0;
    repeat (2) @(negedge clock);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_busywaits", 32'({i_busywait, d_busywait}), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    i_read = 1'b1; i_address = 6'h15;
    #1 chk("i_bw_on_request", 32'(i_busywait), 32'd1);
    @(negedge clock);
    chk("i_mem_read", 32'(mem_read), 32'd1);
    chk("i_mem_address", 32'(mem_address), 32'h15);
    wait_low(1'b0, k);
    chk("i_latency", 32'(k + 1), 32'd7);
    chk("i_readdata", i_readdata, 32'hDEADBEEF);
    chk("i_release_no_cmd", 32'(mem_read), 32'd0);
    i_read = 1'b0;
    @(negedge clock);
    chk("i_idle_bw", 32'(i_busywait), 32'd0);
    n0 = log_n;
    d_write = 1'b1; d_address = 6'h0A; d_writedata = 32'h11223344;
    wait_low(1'b1, k);
    chk("wb_latency", 32'(k), 32'd7);
    d_write = 1'b0;
    @(negedge clock);
    d_read = 1'b1; d_address = 6'h2A;
    wait_low(1'b1, k);
    chk("refill_readdata", d_readdata, 32'hCAFEF00D);
    d_read = 1'b0;
    chk("wb_first_is_write", 32'(log_w[n0]), 32'd1);
    chk("wb_first_addr", 32'(log_a[n0]), 32'h0A);
    chk("refill_is_read", 32'(log_w[n0 + 1]), 32'd0);
    chk("refill_addr", 32'(log_a[n0 + 1]), 32'h2A);
    chk("wb_mem_content", rd(6'h0A), 32'h11223344);
    @(negedge clock);
    i_read = 1'b1; i_address = 6'h16; d_read = 1'b1; d_address = 6'h3F;
    wait_low(1'b1, k);
    chk("sim_d_first_latency", 32'(k), 32'd7);
    chk("sim_i_held", 32'(i_busywait), 32'd1);
    chk("sim_d_readdata", d_readdata, 32'hFFFF0000);
    d_read = 1'b0;
    wait_low(1'b0, k);
    chk("sim_i_latency", 32'(k), 32'd8);
    chk("sim_i_readdata", i_readdata, 32'h0BADF00D);
    i_read = 1'b0;
    @(negedge clock);
    n0 = log_n;
    d_read = 1'b1; d_address = 6'h01; i_read = 1'b1; i_address = 6'h15;
    for (int t = 0; t < 300 && log_n < n0 + 10; t++) @(negedge clock);
    d_read = 1'b0; i_read = 1'b0;
    for (int j = 0; j < 10; j++)
      chk($sformatf("starve_grant%0d", j), 32'(log_a[n0 + j]), (j == 4 || j == 9) ? 32'h15 : 32'h01);
    @(negedge clock);
    d_read = 1'b1; d_address = 6'h03;
    @(negedge clock);
    chk("hold_addr_start", 32'(mem_address), 32'h03);
    d_address = 6'h3F;
    repeat (2) @(negedge clock);
    chk("hold_addr_mid", 32'(mem_address), 32'h03);
    wait_low(1'b1, k);
    chk("hold_readdata", d_readdata, 32'h33333333);
    chk("hold_addr_release", 32'(mem_address), 32'h03);
    d_read = 1'b0;
    @(negedge clock);
    d_write = 1'b1; d_address = 6'h05; d_writedata = 32'hA5A5A5A5;
    @(negedge clock);
    chk("abort_mem_write_on", 32'(mem_write), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_mem_address", 32'(mem_address), 32'd0);
    chk("abort_d_readdata", d_readdata, 32'd0);
    chk("abort_i_readdata", i_readdata, 32'd0);
    chk("abort_d_bw_follows", 32'(d_busywait), 32'd1);
    d_write = 1'b0;
    #1 chk("abort_d_bw_drop", 32'(d_busywait), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_idle", 32'({mem_read, mem_write}), 32'd0);
    chk("abort_not_written", rd(6'h05), 32'h05);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shared_memory_arbiter.md
# shared_memory_arbiter

Two-port arbiter that shares the single 32-bit block-wide data memory between the instruction cache (read-only refills) and the data cache (refills and dirty-block write-backs). It sits between both cache controllers and the data memory, sequences exactly one memory transaction at a time, and returns each cache the same read/write/busywait handshake the memory itself presents. Data-cache traffic has priority, and a starvation counter bounds instruction-side wait time.

## Interface
- STARVE_LIMIT, 4, consecutive data-cache grants allowed while an instruction request waits (range 1-15)
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_read  in  1  instruction-cache block read request, held until i_busywait low
- i_address  in  6  block address {tag,index}
- i_readdata  out  32  returned block, valid in cycle i_busywait falls
- i_busywait  out  1  high while i_read pending or in service
- d_read  in  1  data-cache block read request
- d_write  in  1  data-cache block write request
- d_address  in  6  block address
- d_writedata  in  32  block to write
- d_readdata  out  32  returned block
- d_busywait  out  1  high while d_read/d_write pending or in service
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_address  out  6  to data memory
- mem_writedata  out  32  to data memory
- mem_readdata  in  32  from data memory
- mem_busywait  in  1  from data memory, high while transaction in progress

## Operation
- States: IDLE, GRANT_D, GRANT_I, RELEASE.
- IDLE: no mem_read/mem_write. At posedge, pick requester: d request present and (i_read low or starve_cnt < STARVE_LIMIT) -> GRANT_D; else i_read -> GRANT_I; else stay.
- On entering GRANT_x, latch address, write data and op (read/write) of the winner into registers; mem_* driven from latches only, so requester changes mid-transaction are ignored.
- d_read and d_write both high: treated as write (write-back first); no error output.
- GRANT_x: drive mem_read or mem_write = 1. Flag `started` sets on first posedge sampling mem_busywait = 1. Completion = posedge with started = 1 and mem_busywait = 0: latch mem_readdata into x_readdata (reads only; writes leave x_readdata unchanged), go RELEASE.
- RELEASE (one cycle): mem_read = mem_write = 0; x_busywait = 0 for the served port only; clear started; next state IDLE. Requester must drop its request at the following posedge; a request still high in IDLE is a new transaction.
- x_busywait = (x request high) and not (state == RELEASE and served port == x). Unserved port stays high throughout.
- starve_cnt (4 bit): +1 on each GRANT_D taken while i_read high; cleared on GRANT_I or whenever i_read low in IDLE; saturates at STARVE_LIMIT.
- Reset (any time, including mid-transaction): state IDLE, mem_read = mem_write = 0, mem_address = 0, mem_writedata = 0, i_readdata = d_readdata = 0, starve_cnt = 0, started = 0; busywaits follow the combinational rule (0 with no requests). Aborted transaction is not retried; caches must reissue.

## Timing
- Request sampled at posedge N in IDLE -> mem_read/mem_write high after posedge N.
- Memory with B busy cycles: completion edge N+1+B, RELEASE for cycle after, x_busywait low during it; IDLE at N+2+B+1. Back-to-back service latency per transaction = B + 3 cycles.
- Opposite requester arriving during GRANT/RELEASE is granted at the posedge leaving RELEASE (IDLE entry samples it).
- mem_busywait never seen high (memory absent) -> arbiter stays in GRANT forever; no timeout.
- Outputs mem_* and x_readdata are registered; x_busywait is combinational from request inputs and state.

## Test plan
- Reset: assert reset mid-GRANT_D with mem_write = 1 -> mem_write 0 same cycle, all readdata 0, state IDLE, d_busywait follows d_write.
- Single i refill: i_read, i_address = 6'h15, memory (B = 5) returns 32'hDEADBEEF -> mem_read high one cycle after request, mem_address 6'h15, i_readdata = 32'hDEADBEEF with i_busywait low exactly 1 cycle, total 8 cycles.
- Write-back then refill: d_write addr 6'h0A data 32'h11223344, then d_read addr 6'h2A -> memory sees write then read in order, d_readdata from address 6'h2A.
- Simultaneous: i_read and d_read asserted same cycle -> data side served first, i_busywait held high throughout, icache served next with no idle gap beyond RELEASE/IDLE.
- Starvation, STARVE_LIMIT = 4: d requests continuous, i_read held -> exactly 4 data grants, then instruction grant, then data resumes; starve_cnt back to 0.
- Request change mid-transaction: alter d_address from 6'h03 to 6'h3F during GRANT_D -> mem_address stays 6'h03 until RELEASE.
